ddp_packet_rx: RTL and testbench

// - Clocked receiver for the DDP self-timed Send/Ack packet port. It is the consumer end of PACKET_OUT/Send_out on JOIN_DDP.
// - Synchronises the asynchronous active-low Send strobe and captures the 38-bit packet.
// - Returns an active-low Ack pulse and queues packets in a FIFO for a clocked host or checker.
// - Back-pressure: Ack is withheld while the FIFO is full, which stalls the ring.

---
 rtl/ddp_packet_rx.sv | 143 ++++++++++++++
 tb/tb_ddp_packet_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ddp_packet_rx.sv
// Clocked consumer for the DDP self-timed Send/Ack packet port, with a packet FIFO.
// Optional tag filtering is compiled in with DDP_RX_TAG_CHECK_EN.
module ddp_packet_rx #(
    parameter int PW      = 38,
    parameter int DEPTH   = 8,
    parameter int ACK_LEN = 2
) (
    input  logic                     CLK,
    input  logic                     MR,
    input  logic                     Send_in,
    input  logic [PW-1:0]            PACKET_IN,
    output logic                     Ack_out,
    input  logic                     rd_en,
    output logic [PW-1:0]            rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ACK_LEN + 1);

    typedef enum logic [2:0] {IDLE, CAPT, WAIT, ACK, REL} state_t;

    state_t          state;
    logic            s1, s2, s2_q;
    logic            v1, v2;
    logic            req;
    logic [PW-1:0]   pkt_r;
    logic [CW-1:0]   ack_cnt;
    logic [PW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            pop, push, can_push, tag_ok;
    logic [PW-1:0]   push_data;

    // s2_q only records a high that was really sampled after reset, so a
    // Send held low across MR never looks like a fresh falling edge.
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            v1   <= 1'b0;
            v2   <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1   <= Send_in;
            s2   <= s1;
            v1   <= 1'b1;
            v2   <= v1;
            s2_q <= s2 & v2;
        end
    end

    assign req      = s2_q & ~s2;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = rd_en & ~empty;
    assign can_push = ~full | pop;
    assign rd_data  = empty ? '0 : mem[rptr];

`ifdef DDP_RX_TAG_CHECK_EN
    assign tag_ok = (PACKET_IN[PW-1 -: 3] == 3'b111);

    always_ff @(posedge CLK or posedge MR) begin
        if (MR)
            drop_cnt <= '0;
        else if (state == CAPT && !tag_ok && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign tag_ok   = 1'b1;
    assign drop_cnt = '0;
`endif

    always_comb begin
        push      = 1'b0;
        push_data = pkt_r;
        unique case (state)
            CAPT: begin
                push      = tag_ok & can_push;
                push_data = PACKET_IN;
            end
            WAIT:    push = can_push;
            default: push = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state   <= IDLE;
            Ack_out <= 1'b1;
            pkt_r   <= '0;
            ack_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (req) state <= CAPT;
                CAPT: begin
                    pkt_r <= PACKET_IN;
                    if (!tag_ok || can_push) begin
                        state   <= ACK;
                        Ack_out <= 1'b0;
                        ack_cnt <= CW'(ACK_LEN - 1);
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (can_push) begin
                    state   <= ACK;
                    Ack_out <= 1'b0;
                    ack_cnt <= CW'(ACK_LEN - 1);
                end
                ACK: begin
                    if (ack_cnt == '0) begin
                        state   <= REL;
                        Ack_out <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt - 1'b1;
                    end
                end
                REL: if (s2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= push_data;
    end

endmodule

// File: tb/tb_ddp_packet_rx.sv
// Directed self-checking bench for ddp_packet_rx (default PW=38, DEPTH=8, ACK_LEN=2).
// Expectations follow DDP_RX_TAG_CHECK_EN when it is defined for the build.
module tb_ddp_packet_rx;

    logic        CLK;
    logic        MR;
    logic        Send_in;
    logic [37:0] PACKET_IN;
    logic        Ack_out;
    logic        rd_en;
    logic [37:0] rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    int vectors;
    int miscompares;

    ddp_packet_rx dut (
        .CLK       (CLK),
        .MR        (MR),
        .Send_in   (Send_in),
        .PACKET_IN (PACKET_IN),
        .Ack_out   (Ack_out),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Four-phase send; Send_in stays low if no Ack arrives in the budget.
    task automatic send_pkt(input logic [37:0] p, output bit acked);
        acked = 1'b0;
        @(negedge CLK);
        PACKET_IN = p;
        Send_in   = 1'b0;
        for (int i = 0; i < 12 && !acked; i++) begin
            @(posedge CLK);
            #1;
            if (Ack_out === 1'b0) acked = 1'b1;
        end
        if (acked) begin
            @(negedge CLK);
            Send_in = 1'b1;
            repeat (6) @(posedge CLK);
        end
    endtask

    task automatic pop_one();
        @(negedge CLK);
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    initial begin
        bit acked;
        logic [37:0] p;
        vectors     = 0;
        miscompares = 0;
        MR        = 1'b1;
        Send_in   = 1'b1;
        PACKET_IN = '0;
        rd_en     = 1'b0;

        #50 MR = 1'b0;
        #1;
        chk("rst_ack",   64'(Ack_out),  64'd1);
        chk("rst_empty", 64'(empty),    64'd1);
        chk("rst_full",  64'(full),     64'd0);
        chk("rst_count", 64'(count),    64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_data",  64'(rd_data),  64'd0);

        // Single packet: Send low for 10ns, Ack low on edges 4..5 after the fall.
        repeat (2) @(negedge CLK);
        PACKET_IN = 38'h38_0000_0003;
        Send_in   = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Send_in = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1 chk("lat_e3_high", 64'(Ack_out), 64'd1);
        @(posedge CLK);
        #1 chk("lat_e4_low", 64'(Ack_out), 64'd0);
        @(posedge CLK);
        #1 chk("lat_e5_low", 64'(Ack_out), 64'd0);
        @(posedge CLK);
        #1 chk("lat_e6_high", 64'(Ack_out), 64'd1);
        chk("single_data",  64'(rd_data), 64'h38_0000_0003);
        chk("single_count", 64'(count),   64'd1);
        repeat (3) @(posedge CLK);
        pop_one();
        #1;
        chk("single_pop_empty", 64'(empty), 64'd1);
        chk("single_pop_count", 64'(count), 64'd0);
        pop_one();
        #1 chk("pop_when_empty", 64'(count), 64'd0);

        // Fill the FIFO, then a ninth packet stalls.
        for (int d = 1; d <= 8; d++) begin
            p = 38'h38_0000_0000 | 38'(d);
            send_pkt(p, acked);
            chk("fill_acked", 64'(acked), 64'd1);
        end
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_full",  64'(full),  64'd1);
        send_pkt(38'h38_0000_0009, acked);
        chk("stall_no_ack", 64'(acked), 64'd0);
        chk("stall_ack_hi", 64'(Ack_out), 64'd1);
        chk("stall_count",  64'(count), 64'd8);

        // Pop in the WAIT-exit cycle: push and pop together at count=8.
        @(negedge CLK);
        rd_en = 1'b1;
        @(posedge CLK);
        #1;
        chk("pushpop_ack",   64'(Ack_out), 64'd0);
        chk("pushpop_count", 64'(count),   64'd8);
        chk("pushpop_full",  64'(full),    64'd1);
        @(negedge CLK);
        rd_en   = 1'b0;
        Send_in = 1'b1;
        repeat (6) @(posedge CLK);
        for (int d = 2; d <= 9; d++) begin
            #1 chk("drain_data", 64'(rd_data), 64'h38_0000_0000 | 64'(d));
            pop_one();
        end
        #1 chk("drain_empty", 64'(empty), 64'd1);

        // MR while Ack is low; Send stays low across reset.
        @(negedge CLK);
        PACKET_IN = 38'h38_0000_0077;
        Send_in   = 1'b0;
        acked     = 1'b0;
        for (int i = 0; i < 12 && !acked; i++) begin
            @(posedge CLK);
            #1;
            if (Ack_out === 1'b0) acked = 1'b1;
        end
        chk("mr_pre_ack", 64'(acked), 64'd1);
        MR = 1'b1;
        #1;
        chk("mr_ack_hi", 64'(Ack_out), 64'd1);
        chk("mr_empty",  64'(empty),   64'd1);
        repeat (2) @(negedge CLK);
        MR = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("mr_no_recapture_ack",   64'(Ack_out), 64'd1);
        chk("mr_no_recapture_empty", 64'(empty),   64'd1);
        @(negedge CLK);
        Send_in = 1'b1;
        repeat (4) @(posedge CLK);

        // Tag 3'b011, data 5.
        send_pkt(38'h18_0000_0005, acked);
        chk("tag_acked", 64'(acked), 64'd1);
`ifdef DDP_RX_TAG_CHECK_EN
        chk("tag_empty", 64'(empty),    64'd1);
        chk("tag_drop",  64'(drop_cnt), 64'd1);
`else
        chk("tag_count", 64'(count),    64'd1);
        chk("tag_data",  64'(rd_data),  64'h18_0000_0005);
        chk("tag_drop",  64'(drop_cnt), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
